// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RISC-V M-extension multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle over the
// operating width; trivial cases (div by zero, XLEN signed overflow,
// illegal W ops) take a one-cycle fast path.
module muldiv_iter #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            op_w,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [TAGW-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] rd_out,
  input  logic            flush
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // latched per-op control
  typedef struct packed {
    logic [2:0] op;
    logic       w;
    logic       neg_q;   // product / quotient sign
    logic       neg_r;   // remainder sign (dividend sign)
    logic       fast;    // result already produced at accept
  } ctl_t;

  state_t              state;
  ctl_t                ctl;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc, mcand, acc_n, prod;
  logic [XLEN-1:0]     mplr, rem_q, quo, dvs, rem_n, quo_n, qv, rv, fin;
  logic [XLEN:0]       trial;

  logic                wop, s1, s2, sa, sb, illegal, dz, ovf, fast;
  logic [XLEN-1:0]     ea, eb, ma, mb, fast_val, dvd_w;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // operand conditioning and fast-path detection on the request inputs
  always_comb begin
    wop = op_w && (XLEN == 64);
    s1  = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    s2  = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    ea  = wop ? (s1 ? sext32(rs1[31:0]) : XLEN'(rs1[31:0])) : rs1;
    eb  = wop ? (s2 ? sext32(rs2[31:0]) : XLEN'(rs2[31:0])) : rs2;
    sa  = s1 && ea[XLEN-1];
    sb  = s2 && eb[XLEN-1];
    ma  = sa ? -ea : ea;
    mb  = sb ? -eb : eb;
    dvd_w   = wop ? sext32(rs1[31:0]) : rs1;
    illegal = op_w && ((XLEN == 32) || (op == 3'd1) || (op == 3'd2) || (op == 3'd3));
    dz      = op[2] && (eb == '0);
    // W overflow is left to the iterative path, which yields the right answer
    ovf     = op[2] && !op[0] && !wop && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    fast    = illegal || dz || ovf;
    fast_val = '0;
    if (illegal)  fast_val = '0;
    else if (dz)  fast_val = op[1] ? dvd_w : '1;
    else if (ovf) fast_val = op[1] ? '0 : rs1;
  end

  // one multiply step, one divide step, and the sign-corrected final result
  always_comb begin
    acc_n = mplr[0] ? acc + mcand : acc;
    trial = {rem_q, quo[XLEN-1]} - {1'b0, dvs};
    if (!trial[XLEN]) begin
      rem_n = trial[XLEN-1:0];
      quo_n = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_n = {rem_q[XLEN-2:0], quo[XLEN-1]};
      quo_n = {quo[XLEN-2:0], 1'b0};
    end
    prod = ctl.neg_q ? -acc_n : acc_n;
    qv   = ctl.neg_q ? -quo_n : quo_n;
    rv   = ctl.neg_r ? -rem_n : rem_n;
    if (!ctl.op[2])
      fin = ctl.w ? sext32(prod[31:0]) :
            (ctl.op[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (!ctl.op[1])
      fin = ctl.w ? sext32(qv[31:0]) : qv;
    else
      fin = ctl.w ? sext32(rv[31:0]) : rv;
  end

  // control FSM and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ctl    <= '0;
      cnt    <= '0;
      result <= '0;
      rd_out <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      rem_q  <= '0;
      quo    <= '0;
      dvs    <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state  <= BUSY;
          ctl    <= '{op: op, w: wop, neg_q: sa ^ sb, neg_r: sa, fast: fast};
          cnt    <= fast ? CW'(1) : (wop ? CW'(32) : CW'(XLEN));
          rd_out <= rd_in;
          acc    <= '0;
          mcand  <= {{XLEN{1'b0}}, ma};
          mplr   <= mb;
          rem_q  <= '0;
          // W dividends sit in the top bits so the quotient lands in the low 32
          quo    <= wop ? (ma << (XLEN - 32)) : ma;
          dvs    <= mb;
          if (fast) result <= fast_val;
        end
        BUSY: begin
          acc   <= acc_n;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          rem_q <= rem_n;
          quo   <= quo_n;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            if (!ctl.fast) result <= fin;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
